// File: rtl/axi_write_burst_pkg.sv
// Shared types for the AXI4 write-burst slave: burst encodings, B response codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } wr_state_t;

endpackage

// File: rtl/axi_write_burst_if.sv
// Bundles the AXI4 AW/W/B channels and the beat command stream to the DDR write scheduler.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; slave modport is the burst engine's view.
interface axi_write_burst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_data;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic                  cmd_last;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    output cmd_valid, cmd_addr, cmd_data, cmd_strb, cmd_last,
    input  cmd_ready
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    input  cmd_valid, cmd_addr, cmd_data, cmd_strb, cmd_last,
    output cmd_ready
  );
endinterface

// File: rtl/axi_write_burst_addr_gen.sv
// Next-beat byte address for FIXED/INCR/WRAP bursts from current address, size and length.
// Latency: combinational.
// Backpressure: none; caller registers the result when a beat is accepted.
// Ports: i_addr current beat address, i_size log2 bytes/beat, i_len beats-1,
//        i_burst burst type, o_next_addr address of the following beat.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [7:0]        i_len,
  input  burst_t            i_burst,
  output logic [ADDR_W-1:0] o_next_addr
);

  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_wrap_mask;

  assign w_step = ADDR_W'(1) << i_size;
  // Align down to the beat size before stepping so an unaligned start lands on the grid.
  assign w_incr = (i_addr & ~(w_step - ADDR_W'(1))) + w_step;
  // Wrap window is (len+1)*2^size bytes; only power-of-two lengths reach here.
  assign w_wrap_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      FIXED:   o_next_addr = i_addr;
      INCR:    o_next_addr = w_incr;
      WRAP:    o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default: o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_write_burst.sv
// AXI4 write slave: one AW burst at a time, per-beat addresses to the DDR scheduler, B response.
// Latency: AW->wready 1 cycle, W->cmd_valid 1 cycle, last handoff->bvalid 1 cycle.
// Backpressure: wready follows the one-entry output stage (free or draining this cycle).
// Ports: clk, n_rst (async active-low); bus = AW/W/B channels plus cmd_* beat stream.
// Build option: define AXI_WRAP_BURST_EN to accept WRAP bursts; otherwise WRAP is SLVERR.
module axi_write_burst
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input logic              clk,
  input logic              n_rst,
  axi_write_burst_if.slave bus
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

  wr_state_t           r_state;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [7:0]          r_beat_cnt;
  logic [2:0]          r_size;
  burst_t              r_burst;
  logic                r_err;
  logic                r_all_in;
  logic                r_cmd_valid;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_data;
  logic [STRB_W-1:0]   r_cmd_strb;
  logic                r_cmd_last;
  logic                r_bvalid;
  logic [ID_W-1:0]     r_bid;
  logic [1:0]          r_bresp;

  logic                w_aw_err;
  logic                w_stage_free;
  logic                w_wready;
  logic                w_w_hs;
  logic                w_beat_last;
  logic                w_beat_err;
  logic                w_go_resp;
  logic [ADDR_W-1:0]   w_next_addr;

  always_comb begin
    w_aw_err = (bus.awsize > SIZE_MAX);
    case (burst_t'(bus.awburst))
      FIXED, INCR: ;
`ifdef AXI_WRAP_BURST_EN
      WRAP: if (!(bus.awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                ((bus.awaddr & ((ADDR_W'(1) << bus.awsize) - ADDR_W'(1))) != '0))
              w_aw_err = 1'b1;
`else
      WRAP: w_aw_err = 1'b1;
`endif
      default: w_aw_err = 1'b1;
    endcase
  end

  // Stage can take a beat if empty or being drained this very cycle.
  assign w_stage_free = !r_cmd_valid || bus.cmd_ready;
  // Once all len+1 beats are in, stop taking W until the next AW.
  assign w_wready     = (r_state == DATA) && !r_all_in && w_stage_free;
  assign w_w_hs       = bus.wvalid && w_wready;
  assign w_beat_last  = (r_beat_cnt == r_len);
  // A wlast that disagrees with our own beat count poisons the rest of the burst.
  assign w_beat_err   = r_err || (bus.wlast != w_beat_last);
  // Leave DATA once every beat is in and nothing will remain in the output stage.
  assign w_go_resp    = w_stage_free &&
                        (r_all_in || (w_w_hs && w_beat_last && w_beat_err));

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  assign bus.awready   = (r_state == IDLE);
  assign bus.wready    = w_wready;
  assign bus.bvalid    = r_bvalid;
  assign bus.bid       = r_bid;
  assign bus.bresp     = r_bresp;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_addr  = r_cmd_addr;
  assign bus.cmd_data  = r_cmd_data;
  assign bus.cmd_strb  = r_cmd_strb;
  assign bus.cmd_last  = r_cmd_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_size      <= '0;
      r_burst     <= FIXED;
      r_err       <= 1'b0;
      r_all_in    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_cmd_strb  <= '0;
      r_cmd_last  <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.awvalid) begin
            r_id       <= bus.awid;
            r_addr     <= bus.awaddr;
            r_len      <= bus.awlen;
            r_size     <= bus.awsize;
            r_burst    <= burst_t'(bus.awburst);
            r_beat_cnt <= '0;
            r_err      <= w_aw_err;
            r_all_in   <= 1'b0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (bus.cmd_ready) r_cmd_valid <= 1'b0;
          if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            r_addr     <= w_next_addr;
            r_err      <= w_beat_err;
            if (w_beat_last) r_all_in <= 1'b1;
            // Errored beats are drained from W but never reach the scheduler.
            if (!w_beat_err) begin
              r_cmd_valid <= 1'b1;
              r_cmd_addr  <= r_addr;
              r_cmd_data  <= bus.wdata;
              r_cmd_strb  <= bus.wstrb;
              r_cmd_last  <= w_beat_last;
            end
          end
          if (w_go_resp) begin
            r_state  <= RESP;
            r_bvalid <= 1'b1;
            r_bid    <= r_id;
            r_bresp  <= (r_err || (w_w_hs && w_beat_err)) ? SLVERR : OKAY;
          end
        end
        RESP: begin
          if (bus.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_burst.sv
// Directed bench for axi_write_burst: burst vector table plus stall, latency and reset sequences.
module tb_axi_write_burst;
  import axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int NV     = 9;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  axi_write_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_write_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    int               bad_beat;
    int               ncmd;
    logic [1:0]       resp;
    logic [3:0][31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } beat_t;

  vec_t       vecs [NV];
  beat_t      cmd_q [$];
  logic [3:0] b_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.cmd_valid && bus.cmd_ready)
        cmd_q.push_back('{bus.cmd_addr, bus.cmd_data, bus.cmd_strb, bus.cmd_last});
      if (bus.bvalid && bus.bready)
        b_q.push_back(bus.bid);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [3:0][31:0] a4(input logic [31:0] a0, a1, a2, a3);
    a4[0] = a0; a4[1] = a1; a4[2] = a2; a4[3] = a3;
  endfunction

  function automatic logic [63:0] data_of(input int v, input int k);
    return {32'hDA7A_0000 | 32'(v), 32'(k)};
  endfunction

  function automatic logic [7:0] strb_of(input int k);
    return 8'hFF >> k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All handshake tasks enter and leave 1 time unit after a rising edge.
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic done;
    done = 1'b0;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = bus.awready;
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    if (!done) chk("aw_handshake", {63'd0, done}, 64'd1);
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    logic done;
    done = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = bus.wready;
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    if (!done) chk("w_handshake", {63'd0, done}, 64'd1);
  endtask

  task automatic b_wait(input string name, input logic [3:0] id, input logic [1:0] resp);
    logic done;
    done = 1'b0;
    bus.bready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.bvalid) begin
        done = 1'b1;
        chk({name, "_bid"}, 64'(bus.bid), 64'(id));
        chk({name, "_bresp"}, 64'(bus.bresp), 64'(resp));
      end
      @(posedge clk); #1;
    end
    bus.bready = 1'b0;
    if (!done) chk({name, "_bvalid"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    // id, addr, len, size, burst, bad_beat, ncmd, resp, addrs
    vecs[0] = '{4'h1, 32'h100, 8'd3, 3'd3, 2'b01, -1, 4, OKAY, a4(32'h100, 32'h108, 32'h110, 32'h118)};
    vecs[1] = '{4'h2, 32'h103, 8'd2, 3'd3, 2'b01, -1, 3, OKAY, a4(32'h103, 32'h108, 32'h110, 32'h0)};
    vecs[2] = '{4'h3, 32'h040, 8'd2, 3'd3, 2'b00, -1, 3, OKAY, a4(32'h40, 32'h40, 32'h40, 32'h0)};
    vecs[3] = '{4'h4, 32'h200, 8'd3, 3'd4, 2'b01, -1, 0, SLVERR, a4(32'h0, 32'h0, 32'h0, 32'h0)};
`ifdef AXI_WRAP_BURST_EN
    vecs[4] = '{4'h5, 32'h118, 8'd3, 3'd3, 2'b10, -1, 4, OKAY, a4(32'h118, 32'h100, 32'h108, 32'h110)};
`else
    vecs[4] = '{4'h5, 32'h118, 8'd3, 3'd3, 2'b10, -1, 0, SLVERR, a4(32'h0, 32'h0, 32'h0, 32'h0)};
`endif
    vecs[5] = '{4'h6, 32'h080, 8'd1, 3'd3, 2'b11, -1, 0, SLVERR, a4(32'h0, 32'h0, 32'h0, 32'h0)};
    vecs[6] = '{4'h7, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01, -1, 4, OKAY,
                a4(32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4)};
    vecs[7] = '{4'h8, 32'h200, 8'd3, 3'd3, 2'b01, 1, 1, SLVERR, a4(32'h200, 32'h0, 32'h0, 32'h0)};
    vecs[8] = '{4'h9, 32'h007, 8'd3, 3'd0, 2'b01, -1, 4, OKAY, a4(32'h7, 32'h8, 32'h9, 32'hA)};

    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awsize = '0; bus.awburst = '0; bus.wvalid = 1'b0; bus.wdata = '0;
    bus.wstrb = '0; bus.wlast = 1'b0; bus.bready = 1'b0; bus.cmd_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_wready", 64'(bus.wready), 64'd0);
    chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_cmd_addr", 64'(bus.cmd_addr), 64'd0);
    chk("rst_cmd_data", bus.cmd_data, 64'd0);
    chk("rst_cmd_last", 64'(bus.cmd_last), 64'd0);
    chk("rst_bid_bresp", 64'({bus.bid, bus.bresp}), 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(bus.awready), 64'd1);
    @(posedge clk); #1;

    // Latency and 3-cycle cmd_ready stall
    cmd_q.delete();
    aw_send(4'hC, 32'h300, 8'd3, 3'd3, 2'b01);
    @(negedge clk);
    chk("aw_to_wready", 64'(bus.wready), 64'd1);
    chk("awready_busy", 64'(bus.awready), 64'd0);
    bus.wvalid = 1'b1; bus.wdata = data_of(20, 0); bus.wstrb = strb_of(0); bus.wlast = 1'b0;
    @(posedge clk); #1;
    bus.wdata = data_of(20, 1); bus.wstrb = strb_of(1);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk($sformatf("stall%0d_cmd_valid", s), 64'(bus.cmd_valid), 64'd1);
      chk($sformatf("stall%0d_cmd_addr", s), 64'(bus.cmd_addr), 64'h300);
      chk($sformatf("stall%0d_cmd_data", s), bus.cmd_data, data_of(20, 0));
      chk($sformatf("stall%0d_wready", s), 64'(bus.wready), 64'd0);
    end
    bus.cmd_ready = 1'b1;
    #1;
    chk("simul_wready", 64'(bus.wready), 64'd1);
    @(posedge clk); #1;
    chk("no_bubble_valid", 64'(bus.cmd_valid), 64'd1);
    chk("no_bubble_addr", 64'(bus.cmd_addr), 64'h308);
    w_send(data_of(20, 2), strb_of(2), 1'b0);
    w_send(data_of(20, 3), strb_of(3), 1'b1);
    chk("last_cmd_addr", 64'(bus.cmd_addr), 64'h318);
    chk("last_cmd_last", 64'(bus.cmd_last), 64'd1);
    chk("last_bvalid_early", 64'(bus.bvalid), 64'd0);
    @(posedge clk); #1;
    chk("handoff_to_bvalid", 64'(bus.bvalid), 64'd1);
    b_wait("stall", 4'hC, OKAY);
    chk("stall_ncmd", 64'(cmd_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < cmd_q.size(); k++) begin
      chk($sformatf("stall_addr%0d", k), 64'(cmd_q[k].addr), 64'h300 + 64'(8 * k));
      chk($sformatf("stall_data%0d", k), cmd_q[k].data, data_of(20, k));
    end

    // Burst vector table
    for (int v = 0; v < NV; v++) begin
      logic wl;
      cmd_q.delete();
      aw_send(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
      for (int k = 0; k <= int'(vecs[v].len); k++) begin
        wl = (k == int'(vecs[v].len));
        if (k == vecs[v].bad_beat) wl = !wl;
        w_send(data_of(v, k), strb_of(k), wl);
      end
      b_wait($sformatf("v%0d", v), vecs[v].id, vecs[v].resp);
      chk($sformatf("v%0d_ncmd", v), 64'(cmd_q.size()), 64'(vecs[v].ncmd));
      for (int k = 0; k < cmd_q.size() && k < 4; k++) begin
        chk($sformatf("v%0d_addr%0d", v, k), 64'(cmd_q[k].addr), 64'(vecs[v].exp_addr[k]));
        chk($sformatf("v%0d_data%0d", v, k), cmd_q[k].data, data_of(v, k));
        chk($sformatf("v%0d_strb%0d", v, k), 64'(cmd_q[k].strb), 64'(strb_of(k)));
        chk($sformatf("v%0d_last%0d", v, k), 64'(cmd_q[k].last), 64'(k == int'(vecs[v].len)));
      end
    end

    // Reset pulsed mid-burst
    aw_send(4'hD, 32'h500, 8'd3, 3'd3, 2'b01);
    w_send(data_of(30, 0), strb_of(0), 1'b0);
    w_send(data_of(30, 1), strb_of(1), 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("mid_rst_wready", 64'(bus.wready), 64'd0);
    chk("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("mid_rst_cmd_addr", 64'(bus.cmd_addr), 64'd0);
    chk("mid_rst_cmd_data", bus.cmd_data, 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    cmd_q.delete();
    b_q.delete();
    aw_send(4'hA, 32'h600, 8'd1, 3'd3, 2'b01);
    w_send(data_of(31, 0), strb_of(0), 1'b0);
    w_send(data_of(31, 1), strb_of(1), 1'b1);
    b_wait("post_rst", 4'hA, OKAY);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_nb", 64'(b_q.size()), 64'd1);
    if (b_q.size() > 0) chk("post_rst_bid", 64'(b_q[0]), 64'hA);
    chk("post_rst_ncmd", 64'(cmd_q.size()), 64'd2);
    if (cmd_q.size() > 0) chk("post_rst_addr0", 64'(cmd_q[0].addr), 64'h600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
